bus_arbiter_2to1_16bit: RTL and testbench

BUS_ARBITER_2TO1_16BIT -- requirements
Module: bus_arbiter_2to1_16bit

---
 rtl/bus_arbiter_2to1_16bit.sv | 110 +++++++++++
 tb/tb_bus_arbiter_2to1_16bit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_2to1_16bit.sv
// Two-requester arbiter for a shared 16-bit bus.
// Alternates on ties, caps tenure when the other side waits, registers data.
module bus_arbiter_2to1_16bit #(
  parameter int MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        done0,
  input  logic        done1,
  input  logic [15:0] in0,
  input  logic [15:0] in1,
  output logic        grant0,
  output logic        grant1,
  output logic        select,
  output logic [15:0] q,
  output logic        q_valid,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t      state_q, state_d;
  logic [7:0]  hold_cnt_q, hold_cnt_d;
  logic        last_q, last_d;
  logic [15:0] q_q, q_d;
  logic        q_valid_q, q_valid_d;

  logic        hold_sat;
  logic        rel0, rel1;

  assign hold_sat = (hold_cnt_q == HOLD_LAST);
  assign rel0 = done0 | ~req0 | (hold_sat & req1);
  assign rel1 = done1 | ~req1 | (hold_sat & req0);

  always_comb begin
    state_d   = state_q;
    hold_cnt_d = hold_sat ? hold_cnt_q : hold_cnt_q + 8'd1;
    last_d    = last_q;
    q_d       = q_q;
    q_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        hold_cnt_d = 8'd0;
        if (req0 && req1)
          state_d = last_q ? GRANT0 : GRANT1;
        else if (req0)
          state_d = GRANT0;
        else if (req1)
          state_d = GRANT1;
      end
      GRANT0: begin
        if (req0) begin
          q_d       = in0;
          q_valid_d = 1'b1;
        end
        if (rel0)
          state_d = req1 ? GRANT1 : IDLE;
      end
      GRANT1: begin
        if (req1) begin
          q_d       = in1;
          q_valid_d = 1'b1;
        end
        if (rel1)
          state_d = req0 ? GRANT0 : IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Entering a grant restarts tenure and records who was served.
    if (state_d != state_q) begin
      hold_cnt_d = 8'd0;
      if (state_d == GRANT0) last_d = 1'b0;
      if (state_d == GRANT1) last_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      hold_cnt_q <= 8'd0;
      last_q     <= 1'b1;
      q_q        <= 16'h0000;
      q_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      last_q     <= last_d;
      q_q        <= q_d;
      q_valid_q  <= q_valid_d;
    end
  end

  assign grant0  = (state_q == GRANT0);
  assign grant1  = (state_q == GRANT1);
  assign select  = (state_q == GRANT1);
  assign busy    = grant0 | grant1;
  assign q       = q_q;
  assign q_valid = q_valid_q;

endmodule

// File: tb/tb_bus_arbiter_2to1_16bit.sv
// Directed bench for bus_arbiter_2to1_16bit.
// Each scenario task drives inputs and checks outputs inline.
module tb_bus_arbiter_2to1_16bit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0, req1, done0, done1;
  logic [15:0] in0, in1;
  logic        grant0, grant1, select, q_valid, busy;
  logic [15:0] q;

  int checks = 0;
  int errors = 0;

  bus_arbiter_2to1_16bit #(.MAX_HOLD(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .req1(req1),
    .done0(done0), .done1(done1),
    .in0(in0), .in1(in1),
    .grant0(grant0), .grant1(grant1),
    .select(select), .q(q),
    .q_valid(q_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic go_idle();
    req0 = 0; req1 = 0; done0 = 0; done1 = 0;
    tick(); tick();
  endtask

  task automatic test_reset();
    reset_n = 0;
    req0 = 0; req1 = 0; done0 = 0; done1 = 0;
    in0 = 16'h0; in1 = 16'h0;
    #12;
    chk("rst_grant0", {15'd0, grant0}, 16'd0);
    chk("rst_grant1", {15'd0, grant1}, 16'd0);
    chk("rst_select", {15'd0, select}, 16'd0);
    chk("rst_q", q, 16'h0000);
    chk("rst_qvalid", {15'd0, q_valid}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    reset_n = 1;
    tick();
    chk("idle_busy", {15'd0, busy}, 16'd0);
  endtask

  task automatic test_tie_handover();
    in0 = 16'h1234; in1 = 16'h5678;
    req0 = 1; req1 = 1;
    tick();
    chk("tie_grant0", {15'd0, grant0}, 16'd1);
    chk("tie_grant1", {15'd0, grant1}, 16'd0);
    chk("tie_select", {15'd0, select}, 16'd0);
    done0 = 1;
    tick();
    chk("ho_grant1", {15'd0, grant1}, 16'd1);
    chk("ho_grant0", {15'd0, grant0}, 16'd0);
    chk("ho_select", {15'd0, select}, 16'd1);
    chk("ho_last_q", q, 16'h1234);
    chk("ho_last_qv", {15'd0, q_valid}, 16'd1);
    done0 = 0; req0 = 0;
    tick();
    chk("g1_cap_q", q, 16'h5678);
    done1 = 1;
    tick();
    chk("g1_done_idle", {15'd0, busy}, 16'd0);
    go_idle();
  endtask

  task automatic test_capture();
    in1 = 16'hA5A5; in0 = 16'hFFFF;
    req1 = 1;
    tick();
    chk("cap_grant1", {15'd0, grant1}, 16'd1);
    chk("cap_first_qv", {15'd0, q_valid}, 16'd0);
    tick();
    chk("cap_q1", q, 16'hA5A5);
    chk("cap_qv1", {15'd0, q_valid}, 16'd1);
    tick();
    chk("cap_qv2", {15'd0, q_valid}, 16'd1);
    done1 = 1;
    tick();
    chk("cap_done_q", q, 16'hA5A5);
    chk("cap_done_qv", {15'd0, q_valid}, 16'd1);
    chk("cap_done_idle", {15'd0, grant1}, 16'd0);
    req1 = 0; done1 = 0; in1 = 16'h0000;
    tick();
    chk("cap_hold_q", q, 16'hA5A5);
    chk("cap_after_qv", {15'd0, q_valid}, 16'd0);
    chk("cap_after_busy", {15'd0, busy}, 16'd0);
    go_idle();
  endtask

  task automatic test_hold_limit();
    int n;
    req0 = 1;
    tick();
    req1 = 1;
    n = 1;
    for (int i = 0; i < 40 && grant0 === 1'b1; i++) begin
      tick();
      if (grant0 === 1'b1) n++;
    end
    chk("hold_cycles", 16'(n), 16'd8);
    chk("hold_then_g1", {15'd0, grant1}, 16'd1);
    go_idle();
    req0 = 1;
    tick();
    n = 0;
    for (int i = 0; i < 25; i++) begin
      if (grant0 === 1'b1) n++;
      tick();
    end
    chk("persist_cycles", 16'(n), 16'd25);
    req0 = 0;
    tick();
    chk("drop_busy", {15'd0, busy}, 16'd0);
    chk("drop_qv", {15'd0, q_valid}, 16'd0);
    go_idle();
  endtask

  task automatic test_done_idle_rearb();
    req0 = 1;
    tick();
    done0 = 1;
    tick();
    chk("done_idle_busy", {15'd0, busy}, 16'd0);
    done0 = 0;
    tick();
    chk("rearb_grant0", {15'd0, grant0}, 16'd1);
    req0 = 0;
    tick();
    req0 = 1; req1 = 1;
    tick();
    chk("ptr_grant1", {15'd0, grant1}, 16'd1);
    go_idle();
  endtask

  task automatic test_async_reset();
    in1 = 16'hBEEF;
    req1 = 1;
    tick(); tick();
    chk("pre_rst_q", q, 16'hBEEF);
    #2 reset_n = 0;
    #1;
    chk("ar_grant1", {15'd0, grant1}, 16'd0);
    chk("ar_q", q, 16'h0000);
    chk("ar_qv", {15'd0, q_valid}, 16'd0);
    chk("ar_busy", {15'd0, busy}, 16'd0);
    req0 = 1;
    tick();
    chk("ar_held_q", q, 16'h0000);
    #2 reset_n = 1;
    tick();
    chk("post_rst_tie", {15'd0, grant0}, 16'd1);
    chk("post_rst_sel", {15'd0, select}, 16'd0);
    go_idle();
  endtask

  initial begin
    test_reset();
    test_tie_handover();
    test_capture();
    test_hold_limit();
    test_done_idle_rearb();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
